// File: rtl/bcd_to_binary.sv
// Four-digit BCD to 14-bit binary converter using shift-right / subtract-3.
// Digits above 9 skip the shift loop and report err with bin=0.
module bcd_to_binary (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  bcd3,
    input  logic [3:0]  bcd2,
    input  logic [3:0]  bcd1,
    input  logic [3:0]  bcd0,
    output logic        ready,
    output logic        done_tick,
    output logic [13:0] bin,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] work_q, work_d;
    logic [3:0]  count_q, count_d;
    logic [13:0] bin_q, bin_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic [15:0] sh_bcd, adj_bcd;
    logic [13:0] sh_work;
    logic [3:0]  nib;
    logic        bad_digit;

    assign bad_digit = (bcd3 > 4'd9) || (bcd2 > 4'd9) || (bcd1 > 4'd9) || (bcd0 > 4'd9);

    // One right shift of {bcd, work}, then pull every nibble >= 8 back by 3.
    always_comb begin
        sh_work = {bcd_q[0], work_q[13:1]};
        sh_bcd  = {1'b0, bcd_q[15:1]};
        adj_bcd = sh_bcd;
        nib     = 4'd0;
        for (int i = 0; i < 4; i++) begin
            nib = sh_bcd[4*i +: 4];
            adj_bcd[4*i +: 4] = (nib >= 4'd8) ? nib - 4'd3 : nib;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        work_d  = work_q;
        count_d = count_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = {bcd3, bcd2, bcd1, bcd0};
                    work_d  = 14'd0;
                    count_d = 4'd14;
                    if (bad_digit) begin
                        state_d = DONE;
                        bin_d   = 14'd0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = OP;
                    end
                end
            end
            OP: begin
                bcd_d   = adj_bcd;
                work_d  = sh_work;
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = DONE;
                    bin_d   = sh_work;
                    err_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= 16'd0;
            work_q  <= 14'd0;
            count_q <= 4'd0;
            bin_q   <= 14'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            work_q  <= work_d;
            count_q <= count_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = done_q;
    assign bin       = bin_q;
    assign err       = err_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench: stimulus pushes expected {bin, err, due cycle}; monitor pops on done_tick.
module tb_bcd_to_binary;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
    logic        ready, done_tick, err;
    logic [13:0] bin;

    bcd_to_binary dut (
        .clk(clk), .reset(reset), .start(start),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .ready(ready), .done_tick(done_tick), .bin(bin), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] bin;
        logic        err;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   requests = 0;
    int   dones = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare on every done_tick; flag requests whose due cycle passed.
    always @(negedge clk) begin
        if (!reset) begin
            if (done_tick) begin
                dones++;
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("bin", int'(bin), int'(e.bin));
                    check("err", int'(err), int'(e.err));
                    check("done_cycle", cyc, e.due);
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                check("missing_done", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    // Wait for ready, present digits, push the expected response after the accepting edge.
    task automatic convert(input logic [3:0] d3, d2, d1, d0,
                           input logic [13:0] exp_bin, input logic exp_err, input bit hold);
        int  n;
        exp_t e;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        e.bin = exp_bin;
        e.err = exp_err;
        e.due = cyc + (exp_err ? 1 : 15);
        q.push_back(e);
        requests++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drained", q.size(), 0);
    endtask

    initial begin
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done_tick), 0);
        check("rst_bin", int'(bin), 0);
        check("rst_err", int'(err), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        convert(4'd0, 4'd0, 4'd0, 4'd0, 14'd0, 1'b0, 1'b0);
        drain();
        convert(4'd9, 4'd9, 4'd9, 4'd9, 14'h270F, 1'b0, 1'b0);
        drain();
        convert(4'd1, 4'd2, 4'd3, 4'd4, 14'h04D2, 1'b0, 1'b0);
        drain();
        convert(4'd0, 4'd0, 4'hA, 4'd5, 14'd0, 1'b1, 1'b0);
        drain();
        convert(4'd0, 4'd0, 4'd4, 4'd2, 14'd42, 1'b0, 1'b0);
        drain();
        convert(4'hF, 4'd0, 4'd0, 4'd0, 14'd0, 1'b1, 1'b0);
        drain();

        // Start pulse while busy must be ignored.
        convert(4'd5, 4'd0, 4'd0, 4'd0, 14'd5000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_not_ready", int'(ready), 0);
        bcd3 = 4'd1; bcd2 = 4'd1; bcd1 = 4'd1; bcd0 = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Reset mid-conversion abandons it without a done_tick.
        convert(4'd8, 4'd8, 4'd8, 4'd8, 14'd8888, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        q.delete();
        requests--;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_bin", int'(bin), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_done", int'(done_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        convert(4'd0, 4'd0, 4'd0, 4'd7, 14'd7, 1'b0, 1'b0);
        drain();

        // Back-to-back sweep with start held high.
        for (int v = 0; v <= 9999; v += 97) begin
            convert(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10),
                    14'(v), 1'b0, 1'b1);
        end
        convert(4'd9, 4'd9, 4'd9, 4'd8, 14'd9998, 1'b0, 1'b0);
        drain();
        repeat (20) @(negedge clk);
        check("done_count", dones, requests);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
